// File: rtl/dsp_muladd_arbiter_if.sv
// ----------------------------------------------------------------------------
// dsp_muladd_arbiter_if
// Bundles the requester handshake, the response return and the link to the
// shared multiply-add unit into one interface.
//   slave  : seen by the arbiter (takes requests and dsp_y, drives the rest)
//   master : seen by the environment (clients plus the shared DSP unit)
// Signals:
//   req_valid/req_ready [N]   per-requester handshake
//   req_a/req_b/req_c  [N*W]  operands, requester i at [i*W +: W]
//   dsp_a/dsp_b/dsp_c  [W]    operands to the shared unit, dsp_en its enable
//   dsp_y              [W]    result from the shared unit
//   rsp_valid [N], rsp_y [W]  one-cycle result strobe and data
//   busy                      any operation in flight
// ----------------------------------------------------------------------------
interface dsp_muladd_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*W-1:0] req_c;
  logic [W-1:0]   dsp_a;
  logic [W-1:0]   dsp_b;
  logic [W-1:0]   dsp_c;
  logic           dsp_en;
  logic [W-1:0]   dsp_y;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           busy;

  modport slave (
    input  req_valid, req_a, req_b, req_c, dsp_y,
    output req_ready, dsp_a, dsp_b, dsp_c, dsp_en, rsp_valid, rsp_y, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_c, dsp_y,
    input  req_ready, dsp_a, dsp_b, dsp_c, dsp_en, rsp_valid, rsp_y, busy
  );
endinterface

// File: rtl/dsp_muladd_arbiter.sv
// ----------------------------------------------------------------------------
// dsp_muladd_arbiter
// Round-robin scheduler sharing one pipelined multiply-add unit
// (y = a*b + c, W-bit wrap) among N requesters. One operation is issued per
// cycle; a tag pipe of LATENCY+1 stages follows each operation through the
// unit so its result can be steered back to the requester that issued it.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous, active-low reset
//   io_bus  : dsp_muladd_arbiter_if.slave (requests, DSP link, responses)
// ----------------------------------------------------------------------------
module dsp_muladd_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  dsp_muladd_arbiter_if.slave   io_bus
);
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [TW-1:0]  r_ptr;
  logic [CW-1:0]  r_cnt [N];
  logic [LATENCY:0] r_tv;
  logic [TW-1:0]  r_tag [LATENCY+1];
  logic [W-1:0]   r_dsp_a;
  logic [W-1:0]   r_dsp_b;
  logic [W-1:0]   r_dsp_c;
  logic [N-1:0]   r_rsp_valid;
  logic [W-1:0]   r_rsp_y;

  logic [N-1:0]   w_elig;
  logic           w_gnt_vld;
  logic [TW-1:0]  w_gnt_idx;
  logic [TW-1:0]  w_cand;
  logic           w_fire;
  logic           w_ret_vld;
  logic [TW-1:0]  w_ret_idx;

  function automatic logic [N-1:0] f_onehot(input logic [TW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Eligibility: valid request and room for another in-flight operation.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N; i++) begin
      w_elig[i] = io_bus.req_valid[i] && (r_cnt[i] < CW'(MAX_OUT));
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = TW'((int'(r_ptr) + k) % N);
      if (!w_gnt_vld && w_elig[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end else begin
        w_gnt_idx = w_gnt_idx;
      end
    end
  end

  // No accepts while reset is held, so nothing enters the pipe.
  assign w_fire    = w_gnt_vld & reset;
  assign w_ret_vld = r_tv[LATENCY];
  assign w_ret_idx = r_tag[LATENCY];

  // Operand capture, tag pipe, RR pointer and response register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr       <= TW'(N - 1);
      r_tv        <= '0;
      r_dsp_a     <= '0;
      r_dsp_b     <= '0;
      r_dsp_c     <= '0;
      r_rsp_valid <= '0;
      r_rsp_y     <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      if (w_fire) begin
        r_dsp_a <= io_bus.req_a[w_gnt_idx*W +: W];
        r_dsp_b <= io_bus.req_b[w_gnt_idx*W +: W];
        r_dsp_c <= io_bus.req_c[w_gnt_idx*W +: W];
        r_ptr   <= w_gnt_idx;
      end
      // Stage s lines up with the operation issued s cycles ago, so stage
      // LATENCY is valid in the same cycle its result sits on dsp_y.
      r_tv     <= {r_tv[LATENCY-1:0], w_fire};
      r_tag[0] <= w_gnt_idx;
      for (int s = 1; s <= LATENCY; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      r_rsp_valid <= w_ret_vld ? f_onehot(w_ret_idx) : '0;
      r_rsp_y     <= io_bus.dsp_y;
    end
  end

  // Per-requester outstanding counters: +1 on accept, -1 as the response
  // strobe is registered; both at once leaves the count unchanged.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        r_cnt[i] <= '0;
      end else begin
        case ({w_fire && (w_gnt_idx == TW'(i)), w_ret_vld && (w_ret_idx == TW'(i))})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  assign io_bus.req_ready = w_fire ? f_onehot(w_gnt_idx) : '0;
  assign io_bus.dsp_a     = r_dsp_a;
  assign io_bus.dsp_b     = r_dsp_b;
  assign io_bus.dsp_c     = r_dsp_c;
  // The shared pipeline never stalls; it only stops during reset.
  assign io_bus.dsp_en    = reset;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_y     = r_rsp_y;
  assign io_bus.busy      = (|r_tv) | (|r_rsp_valid);
endmodule

// File: tb/tb_dsp_muladd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dsp_muladd_arbiter
// Bench for dsp_muladd_arbiter. dut_a: N=4 W=8 LATENCY=2 MAX_OUT=4.
// dut_b: N=4 W=8 LATENCY=4 MAX_OUT=2 (outstanding-limit sequence).
// Each DUT gets a behavioural pipelined multiply-add model on its DSP link.
// ----------------------------------------------------------------------------
module tb_dsp_muladd_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dsp_muladd_arbiter_if #(.N(4), .W(8)) ifa ();
  dsp_muladd_arbiter_if #(.N(4), .W(8)) ifb ();

  dsp_muladd_arbiter #(.N(4), .W(8), .LATENCY(2), .MAX_OUT(4)) dut_a (
    .clock (clock),
    .reset (reset),
    .io_bus(ifa.slave)
  );

  dsp_muladd_arbiter #(.N(4), .W(8), .LATENCY(4), .MAX_OUT(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .io_bus(ifb.slave)
  );

  // Shared-unit models: operands presented after edge k give y after edge k+L.
  logic [7:0] pa [2];
  logic [7:0] pb [4];
  always @(posedge clock) begin
    if (ifa.dsp_en) begin
      pa[0] <= ifa.dsp_a * ifa.dsp_b + ifa.dsp_c;
      pa[1] <= pa[0];
    end
  end
  always @(posedge clock) begin
    if (ifb.dsp_en) begin
      pb[0] <= ifb.dsp_a * ifb.dsp_b + ifb.dsp_c;
      for (int s = 1; s < 4; s++) pb[s] <= pb[s-1];
    end
  end
  assign ifa.dsp_y = pa[1];
  assign ifb.dsp_y = pb[3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] vld;
    logic [7:0] y;
  } exp_t;
  exp_t sbq [$];
  int   hsq [$];

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] y;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] y);
    exp_t e;
    e.vld = 4'(1 << idx);
    e.y   = y;
    sbq.push_back(e);
  endtask

  task automatic set_op_a(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    ifa.req_a[idx*8 +: 8] = a;
    ifa.req_b[idx*8 +: 8] = b;
    ifa.req_c[idx*8 +: 8] = c;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    sbq.delete();
    hsq.delete();
  endtask

  task automatic drain_a(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  // Response scoreboard for dut_a; handshakes record the cycle their strobe is due.
  always @(negedge clock) begin
    exp_t me;
    int   due;
    if (reset) begin
      if (ifa.rsp_valid != 4'b0000) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(ifa.rsp_valid), 32'd0);
        end else begin
          me = sbq.pop_front();
          chk("rsp_tag", 32'(ifa.rsp_valid), 32'(me.vld));
          chk("rsp_y", 32'(ifa.rsp_y), 32'(me.y));
          chk("rsp_busy", 32'(ifa.busy), 32'd1);
          if (hsq.size() != 0) begin
            due = hsq.pop_front();
            chk("rsp_latency", 32'(cyc), 32'(due));
          end else begin
            chk("rsp_no_issue", 32'(ifa.rsp_valid), 32'd0);
          end
        end
      end
      if ((ifa.req_valid & ifa.req_ready) != 4'b0000) hsq.push_back(cyc + 4);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int found;
    tbl[0] = '{idx: 0, a: 8'd127, b: 8'd1,   c: 8'hCE, y: 8'd77};
    tbl[1] = '{idx: 2, a: 8'd127, b: 8'd2,   c: 8'h00, y: 8'hFE};
    tbl[2] = '{idx: 2, a: 8'h80,  b: 8'hFF,  c: 8'h00, y: 8'h80};
    tbl[3] = '{idx: 1, a: 8'd5,   b: 8'hFD,  c: 8'd10, y: 8'hFB};
    tbl[4] = '{idx: 3, a: 8'h10,  b: 8'h10,  c: 8'h01, y: 8'h01};
    tbl[5] = '{idx: 0, a: 8'h00,  b: 8'h55,  c: 8'h7F, y: 8'h7F};

    ifa.req_valid = 4'b1111;
    ifa.req_a = '0; ifa.req_b = '0; ifa.req_c = '0;
    ifb.req_valid = 4'b0000;
    ifb.req_a = '0; ifb.req_b = '0; ifb.req_c = '0;
    reset = 1'b0;

    // Reset state, with requests pending to prove they are held off.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(ifa.req_ready), 32'd0);
    chk("rst_dsp_en", 32'(ifa.dsp_en), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(ifa.rsp_y), 32'd0);
    chk("rst_dsp_abc", 32'({ifa.dsp_a, ifa.dsp_b, ifa.dsp_c}), 32'd0);
    @(posedge clock); #1;
    ifa.req_valid = 4'b0000;
    reset = 1'b1;
    @(negedge clock);
    chk("run_dsp_en", 32'(ifa.dsp_en), 32'd1);

    // Single operations from the vector table.
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      set_op_a(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].c);
      ifa.req_valid = 4'(1 << tbl[i].idx);
      push_exp(tbl[i].idx, tbl[i].y);
      n = 0;
      @(negedge clock);
      while (ifa.req_ready == 4'b0000 && n < 10) begin
        @(negedge clock);
        n++;
      end
      chk($sformatf("vec%0d_grant", i), 32'(ifa.req_ready), 32'(1 << tbl[i].idx));
      if (i == 0) chk("vec0_first_cycle", 32'(n), 32'd0);
      @(posedge clock); #1;
      ifa.req_valid = 4'b0000;
      chk($sformatf("vec%0d_busy", i), 32'(ifa.busy), 32'd1);
      drain_a($sformatf("vec%0d_rsp_seen", i));
    end

    // Fairness from reset: grant order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < 4; i++) set_op_a(i, 8'(i + 1), 8'd3, 8'(i));
    ifa.req_valid = 4'b1111;
    for (int g = 0; g < 8; g++) push_exp(g % 4, 8'(4 * (g % 4) + 3));
    for (int g = 0; g < 8; g++) begin
      @(negedge clock);
      chk($sformatf("rr_order%0d", g), 32'(ifa.req_ready), 32'(1 << (g % 4)));
    end
    @(posedge clock); #1;
    ifa.req_valid = 4'b0000;
    drain_a("rr_rsp_seen");

    // Reset with three operations in flight: none may be answered.
    @(posedge clock); #1;
    ifa.req_valid = 4'b0111;
    repeat (3) @(posedge clock);
    #1;
    ifa.req_valid = 4'b0000;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    hsq.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("flush_no_rsp", 32'(ifa.rsp_valid), 32'd0);
    end
    chk("flush_busy", 32'(ifa.busy), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("flush_cnt%0d", i), 32'(dut_a.r_cnt[i]), 32'd0);

    // After reset requester 0 wins first even though 3 follows the last grant.
    @(posedge clock); #1;
    ifa.req_valid = 4'b1111;
    for (int g = 0; g < 4; g++) push_exp(g, 8'(4 * g + 3));
    for (int g = 0; g < 4; g++) begin
      @(negedge clock);
      chk($sformatf("post_rst_order%0d", g), 32'(ifa.req_ready), 32'(1 << g));
    end
    @(posedge clock); #1;
    ifa.req_valid = 4'b0000;
    drain_a("post_rst_rsp_seen");

    // Idle: nothing moves and the DSP operands keep the last grant (req 3).
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (ifa.req_ready != 4'b0000 || ifa.rsp_valid != 4'b0000 || ifa.busy) n++;
    end
    chk("idle_quiet", 32'(n), 32'd0);
    chk("idle_hold_abc", 32'({ifa.dsp_a, ifa.dsp_b, ifa.dsp_c}), 32'h040303);

    // Outstanding limit on dut_b (MAX_OUT=2, LATENCY=4).
    @(posedge clock); #1;
    ifb.req_a[8 +: 8] = 8'd3;  ifb.req_b[8 +: 8] = 8'd4;  ifb.req_c[8 +: 8] = 8'd5;
    ifb.req_a[24 +: 8] = 8'd2; ifb.req_b[24 +: 8] = 8'd2; ifb.req_c[24 +: 8] = 8'd2;
    ifb.req_valid = 4'b0010;
    @(negedge clock);
    chk("lim_acc1", 32'(ifb.req_ready), 32'h2);
    @(negedge clock);
    chk("lim_acc2", 32'(ifb.req_ready), 32'h2);
    @(negedge clock);
    chk("lim_stall", 32'(ifb.req_ready), 32'h0);
    @(posedge clock); #1;
    ifb.req_valid = 4'b1010;
    @(negedge clock);
    chk("lim_other", 32'(ifb.req_ready), 32'h8);
    @(posedge clock); #1;
    ifb.req_valid = 4'b0010;
    n = 0;
    found = 0;
    while (found == 0 && n < 12) begin
      @(negedge clock);
      if (ifb.rsp_valid[1]) begin
        chk("lim_release", 32'(ifb.req_ready), 32'h2);
        chk("lim_rsp_y", 32'(ifb.rsp_y), 32'h11);
        found = 1;
      end else begin
        chk("lim_hold", 32'(ifb.req_ready), 32'h0);
      end
      n++;
    end
    chk("lim_rsp_seen", 32'(found), 32'd1);
    @(posedge clock); #1;
    ifb.req_valid = 4'b0000;
    repeat (20) @(negedge clock);
    chk("lim_drained_busy", 32'(ifb.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
